// File: rtl/ring_decoder_monitor_if.sv
// Bus bundle for ring_decoder_monitor: the sample/clear inputs and all status outputs.
interface ring_decoder_monitor_if #(
  parameter int unsigned NBITS = 4,
  parameter int unsigned IDXW  = $clog2(NBITS)
);
  logic             ring_valid;
  logic [NBITS-1:0] ring_in;
  logic             err_clr;
  logic [IDXW-1:0]  index;
  logic             index_valid;
  logic             locked;
  logic             err_illegal;
  logic             err_seq;
  logic             err_sticky;
  logic [7:0]       err_count;
  logic [7:0]       rev_count;

  // Driver of samples, consumer of status.
  modport master (
    output ring_valid, ring_in, err_clr,
    input  index, index_valid, locked, err_illegal, err_seq,
           err_sticky, err_count, rev_count
  );

  // The monitor itself.
  modport slave (
    input  ring_valid, ring_in, err_clr,
    output index, index_valid, locked, err_illegal, err_seq,
           err_sticky, err_count, rev_count
  );
endinterface

// File: rtl/ring_decoder_monitor.sv
// One-hot ring counter monitor: decodes the set-bit position, tracks lock to
// the left-rotating sequence (HUNT/SYNC/LOCKED) and counts errors/revolutions.
module ring_decoder_monitor #(
  parameter int unsigned NBITS = 4,
  parameter int unsigned IDXW  = $clog2(NBITS)
) (
  input  logic                 clk,
  input  logic                 reset,
  ring_decoder_monitor_if.slave bus
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] prev_q;
  logic [IDXW-1:0]  index_q;
  logic             index_valid_q;
  logic             locked_q;
  logic             err_illegal_q, err_illegal_d;
  logic             err_seq_q, err_seq_d;
  logic             err_sticky_q;
  logic [7:0]       err_count_q;
  logic [7:0]       rev_count_q;

  logic             legal;
  logic             match;
  logic             rev_hit;
  logic             err_ev;
  logic [NBITS-1:0] expected;
  logic [IDXW-1:0]  enc;

  // Sample classification, position decode and next-state selection.
  always_comb begin
    legal    = (bus.ring_in != '0) &&
               ((bus.ring_in & (bus.ring_in - NBITS'(1))) == '0);
    expected = {prev_q[NBITS-2:0], prev_q[NBITS-1]};
    // prev is zero after reset, so expected is zero and can never match a legal word.
    match    = legal && (bus.ring_in == expected);
    rev_hit  = bus.ring_in[0] && prev_q[NBITS-1];
    enc      = '0;
    for (int unsigned i = 0; i < NBITS; i++) begin
      if (bus.ring_in[i]) enc = IDXW'(i);
    end

    state_d       = state_q;
    err_illegal_d = 1'b0;
    err_seq_d     = 1'b0;
    if (bus.ring_valid) begin
      case (state_q)
        HUNT: begin
          if (legal) state_d = SYNC;
        end
        SYNC: begin
          if (!legal)     state_d = HUNT;
          else if (match) state_d = LOCKED;
        end
        LOCKED: begin
          if (!legal) begin
            state_d       = HUNT;
            err_illegal_d = 1'b1;
          end else if (!match) begin
            state_d   = SYNC;
            err_seq_d = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    err_ev = err_illegal_d || err_seq_d;
  end

  // State, decoded index, registered pulses and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      prev_q        <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_count_q   <= '0;
      rev_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      locked_q      <= (state_d == LOCKED);
      err_illegal_q <= err_illegal_d;
      err_seq_q     <= err_seq_d;
      index_valid_q <= bus.ring_valid && legal;

      if (bus.ring_valid && legal) begin
        prev_q  <= bus.ring_in;
        index_q <= enc;
      end

      if (bus.ring_valid && state_q == LOCKED && match && rev_hit &&
          rev_count_q != '1) begin
        rev_count_q <= rev_count_q + 8'd1;
      end

      // A simultaneous clear and error leaves exactly that one error recorded.
      if (err_ev) begin
        err_sticky_q <= 1'b1;
        if (bus.err_clr)             err_count_q <= 8'd1;
        else if (err_count_q != '1)  err_count_q <= err_count_q + 8'd1;
      end else if (bus.err_clr) begin
        err_sticky_q <= 1'b0;
        err_count_q  <= '0;
      end
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.locked      = locked_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_seq     = err_seq_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.err_count   = err_count_q;
  assign bus.rev_count   = rev_count_q;

endmodule

// File: tb/tb_ring_decoder_monitor.sv
// Directed bench for ring_decoder_monitor (NBITS=4): vector table plus
// hand-written saturation and reset sequences.
module tb_ring_decoder_monitor;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ring_decoder_monitor_if #(.NBITS(4), .IDXW(2)) bus ();

  ring_decoder_monitor #(.NBITS(4), .IDXW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] ring;
    logic       clr;
    logic [1:0] e_idx;
    logic       e_iv;
    logic       e_lk;
    logic       e_ill;
    logic       e_seq;
    logic       e_stk;
    logic [7:0] e_cnt;
    logic [7:0] e_rev;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] ring,
                              input logic c, input logic [1:0] ix, input logic iv,
                              input logic lk, input logic il, input logic sq,
                              input logic st, input logic [7:0] cnt,
                              input logic [7:0] rv);
    vec_t t;
    t.rst = r;  t.vld = v;  t.ring = ring; t.clr = c;
    t.e_idx = ix; t.e_iv = iv; t.e_lk = lk; t.e_ill = il; t.e_seq = sq;
    t.e_stk = st; t.e_cnt = cnt; t.e_rev = rv;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic v, input logic [3:0] ring, input logic c);
    reset          = r;
    bus.ring_valid = v;
    bus.ring_in    = ring;
    bus.err_clr    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t t, input int n);
    drive(t.rst, t.vld, t.ring, t.clr);
    chk($sformatf("v%0d index", n),       32'(bus.index),       32'(t.e_idx));
    chk($sformatf("v%0d index_valid", n), 32'(bus.index_valid), 32'(t.e_iv));
    chk($sformatf("v%0d locked", n),      32'(bus.locked),      32'(t.e_lk));
    chk($sformatf("v%0d err_illegal", n), 32'(bus.err_illegal), 32'(t.e_ill));
    chk($sformatf("v%0d err_seq", n),     32'(bus.err_seq),     32'(t.e_seq));
    chk($sformatf("v%0d err_sticky", n),  32'(bus.err_sticky),  32'(t.e_stk));
    chk($sformatf("v%0d err_count", n),   32'(bus.err_count),   32'(t.e_cnt));
    chk($sformatf("v%0d rev_count", n),   32'(bus.rev_count),   32'(t.e_rev));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset          = 1'b1;
    bus.ring_valid = 1'b0;
    bus.ring_in    = '0;
    bus.err_clr    = 1'b0;

    //             rst vld ring     clr  idx iv lk il sq st cnt rev
    vq.push_back(mk(1, 0, 4'b0000, 0,   0,  0, 0, 0, 0, 0, 0, 0)); // reset
    vq.push_back(mk(0, 1, 4'b0001, 0,   0,  1, 0, 0, 0, 0, 0, 0)); // HUNT->SYNC
    vq.push_back(mk(0, 1, 4'b0010, 0,   1,  1, 1, 0, 0, 0, 0, 0)); // lock
    vq.push_back(mk(0, 1, 4'b0100, 0,   2,  1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 4'b1111, 0,   2,  0, 1, 0, 0, 0, 0, 0)); // valid=0 ignored
    vq.push_back(mk(0, 1, 4'b1000, 0,   3,  1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 4'b0001, 0,   0,  1, 1, 0, 0, 0, 0, 1)); // revolution
    vq.push_back(mk(0, 1, 4'b0010, 0,   1,  1, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 4'b0110, 0,   1,  0, 0, 1, 0, 1, 1, 1)); // illegal in LOCKED
    vq.push_back(mk(0, 1, 4'b0000, 0,   1,  0, 0, 0, 0, 1, 1, 1)); // illegal in HUNT
    vq.push_back(mk(0, 1, 4'b0100, 0,   2,  1, 0, 0, 0, 1, 1, 1));
    vq.push_back(mk(0, 1, 4'b1000, 0,   3,  1, 1, 0, 0, 1, 1, 1));
    vq.push_back(mk(0, 1, 4'b0001, 0,   0,  1, 1, 0, 0, 1, 1, 2)); // wrap
    vq.push_back(mk(0, 1, 4'b0010, 0,   1,  1, 1, 0, 0, 1, 1, 2));
    vq.push_back(mk(0, 1, 4'b1000, 0,   3,  1, 0, 0, 1, 1, 2, 2)); // skip -> SYNC
    vq.push_back(mk(0, 1, 4'b0001, 0,   0,  1, 1, 0, 0, 1, 2, 2)); // relock, no rev
    vq.push_back(mk(0, 1, 4'b0001, 0,   0,  1, 0, 0, 1, 1, 3, 2)); // held word
    vq.push_back(mk(0, 1, 4'b0010, 1,   1,  1, 1, 0, 0, 0, 0, 2)); // clr alone
    vq.push_back(mk(0, 1, 4'b0011, 1,   1,  0, 0, 1, 0, 1, 1, 2)); // clr + illegal
    vq.push_back(mk(0, 0, 4'b0000, 1,   1,  0, 0, 0, 0, 0, 0, 2)); // clr, valid=0
    vq.push_back(mk(0, 1, 4'b0100, 0,   2,  1, 0, 0, 0, 0, 0, 2));
    vq.push_back(mk(0, 1, 4'b1000, 0,   3,  1, 1, 0, 0, 0, 0, 2));
    vq.push_back(mk(0, 1, 4'b0100, 1,   2,  1, 0, 0, 1, 1, 1, 2)); // clr + seq err
    vq.push_back(mk(0, 1, 4'b0000, 0,   2,  0, 0, 0, 0, 1, 1, 2)); // illegal in SYNC
    vq.push_back(mk(0, 0, 4'b0001, 0,   2,  0, 0, 0, 0, 1, 1, 2)); // valid=0 in HUNT

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Relock, then run 300 revolutions to saturate rev_count.
    drive(0, 1, 4'b0001, 0);
    drive(0, 1, 4'b0010, 0);
    chk("relock locked", 32'(bus.locked), 32'd1);
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 4'b0100, 0);
      drive(0, 1, 4'b1000, 0);
      drive(0, 1, 4'b0001, 0);
      drive(0, 1, 4'b0010, 0);
      if (i == 251) chk("rev_count pre-sat", 32'(bus.rev_count), 32'd254);
    end
    chk("rev_count sat",       32'(bus.rev_count), 32'd255);
    chk("rev err_count",       32'(bus.err_count), 32'd1);
    chk("rev locked",          32'(bus.locked),    32'd1);

    // 260 sequence errors (held word then relock) to saturate err_count.
    for (int i = 0; i < 260; i++) begin
      drive(0, 1, 4'b0010, 0);
      if (i == 0) chk("seq err pulse", 32'(bus.err_seq), 32'd1);
      drive(0, 1, 4'b0100, 0);
    end
    chk("err_count sat",       32'(bus.err_count),  32'd255);
    chk("err_sticky sat",      32'(bus.err_sticky), 32'd1);
    chk("rev_count held",      32'(bus.rev_count),  32'd255);
    chk("locked after errs",   32'(bus.locked),     32'd1);

    // Reset wins over a valid sample and a clear in the same cycle.
    apply(mk(1, 1, 4'b1000, 1, 0, 0, 0, 0, 0, 0, 0, 0), 100);
    // After release, a lone legal sample only reaches SYNC.
    apply(mk(0, 1, 4'b1000, 0, 3, 1, 0, 0, 0, 0, 0, 0), 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
